// File: rtl/potential_decay_pkg.sv
// Shared float32 field constants, storage type and sweep FSM states for the potential decay array.
package potential_decay_pkg;

  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned MAN_W    = 23;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;

  typedef logic [31:0] float32_t;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDone
  } state_t;

  function automatic float32_t signed_zero(input float32_t v);
    return {v[SIGN_BIT], 31'b0};
  endfunction

endpackage

// File: rtl/potential_decay_array_fp_pow2_div.sv
// Combinational float32 divide by 2^rate via exponent subtraction; flushes to signed zero
// instead of producing denormals, passes Inf/NaN through.
module fp_pow2_div
  import potential_decay_pkg::*;
#(
  parameter int unsigned RATE_W = 3
) (
  input  float32_t          value,
  input  logic [RATE_W-1:0] rate,
  output float32_t          result
);

  localparam int unsigned CmpW = RATE_W + 8;

  logic [7:0]       exp_in;
  logic [MAN_W-1:0] man_in;
  logic [CmpW-1:0]  exp_wide;
  logic [CmpW-1:0]  rate_wide;

  assign exp_in    = value[EXP_MSB:EXP_LSB];
  assign man_in    = value[MAN_W-1:0];
  assign exp_wide  = CmpW'(exp_in);
  assign rate_wide = CmpW'(rate);

  always_comb begin
    result = value;
    if (exp_in == EXP_MAX) begin
      result = value;
    end else if ((exp_in == 8'd0) || (exp_wide <= rate_wide)) begin
      result = signed_zero(value);
    end else begin
      // exp_in > rate here, so the low byte of the rate holds all of it
      result = {value[SIGN_BIT], exp_in - rate_wide[7:0], man_in};
    end
  end

endmodule

// File: rtl/potential_decay_array.sv
// Array of float32 neuron potentials with per-neuron decay rates and a one-neuron-per-cycle
// decay sweep. Optional trace stream enabled by defining POTENTIAL_DECAY_TRACE_EN.
module potential_decay_array
  import potential_decay_pkg::*;
#(
  parameter int unsigned NUM_NEURONS  = 16,
  parameter int unsigned RATE_W       = 3,
  parameter int unsigned DEFAULT_RATE = 1,
  localparam int unsigned IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sweep_start,
  output logic              busy,
  output logic              sweep_done,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [31:0]       wr_potential,
  input  logic              cfg_en,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [RATE_W-1:0] cfg_rate,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [31:0]       rd_potential,
  output logic              trace_valid,
  output logic [IDX_W-1:0]  trace_idx,
  output logic [31:0]       trace_value
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_NEURONS - 1);

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              busy_q;
  logic              done_q;
  float32_t          pot_q  [NUM_NEURONS];
  logic [RATE_W-1:0] rate_q [NUM_NEURONS];
  float32_t          decayed;
  logic              sweeping;
  logic              collide;

  assign sweeping = (state_q == StSweep);
  // A host write to the neuron under decay wins; the decay result is dropped.
  assign collide  = sweeping && wr_en && (wr_idx == idx_q);

  fp_pow2_div #(
    .RATE_W(RATE_W)
  ) u_div (
    .value (pot_q[idx_q]),
    .rate  (rate_q[idx_q]),
    .result(decayed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sweep_start) begin
            state_q <= StSweep;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StSweep: begin
          if (idx_q == LastIdx) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        pot_q[i]  <= '0;
        rate_q[i] <= RATE_W'(DEFAULT_RATE);
      end
    end else begin
      if (sweeping && !collide) begin
        pot_q[idx_q] <= decayed;
      end
      if (wr_en) begin
        pot_q[wr_idx] <= wr_potential;
      end
      if (cfg_en) begin
        rate_q[cfg_idx] <= cfg_rate;
      end
    end
  end

  assign busy         = busy_q;
  assign sweep_done   = done_q;
  assign rd_potential = pot_q[rd_idx];

`ifdef POTENTIAL_DECAY_TRACE_EN
  logic             trace_valid_q;
  logic [IDX_W-1:0] trace_idx_q;
  float32_t         trace_value_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_valid_q <= 1'b0;
      trace_idx_q   <= '0;
      trace_value_q <= '0;
    end else begin
      trace_valid_q <= sweeping;
      if (sweeping) begin
        trace_idx_q   <= idx_q;
        trace_value_q <= collide ? wr_potential : decayed;
      end
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_idx   = trace_idx_q;
  assign trace_value = trace_value_q;
`else
  assign trace_valid = 1'b0;
  assign trace_idx   = '0;
  assign trace_value = '0;
`endif

endmodule

// File: tb/tb_potential_decay_array.sv
// Scoreboard bench for potential_decay_array: expected potentials queued when a sweep is set up,
// popped and compared against the read port after the sweep completes.
module tb_potential_decay_array;

  localparam int unsigned N  = 16;
  localparam int unsigned RW = 3;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sweep_start;
  logic          busy;
  logic          sweep_done;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [31:0]   wr_potential;
  logic          cfg_en;
  logic [IW-1:0] cfg_idx;
  logic [RW-1:0] cfg_rate;
  logic [IW-1:0] rd_idx;
  logic [31:0]   rd_potential;
  logic          trace_valid;
  logic [IW-1:0] trace_idx;
  logic [31:0]   trace_value;

  potential_decay_array #(
    .NUM_NEURONS (N),
    .RATE_W      (RW),
    .DEFAULT_RATE(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sweep_start (sweep_start),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_potential(wr_potential),
    .cfg_en      (cfg_en),
    .cfg_idx     (cfg_idx),
    .cfg_rate    (cfg_rate),
    .rd_idx      (rd_idx),
    .rd_potential(rd_potential),
    .trace_valid (trace_valid),
    .trace_idx   (trace_idx),
    .trace_value (trace_value)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_pot  [N];
  logic [RW-1:0] m_rate [N];
  logic [31:0] sb [$];

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [31:0]   val;
  } trace_t;
  trace_t tr_q [$];

  // Host events applied during a sweep: kind 0 = potential write, 1 = rate write.
  int          ev_cycle [6];
  int          ev_kind  [6];
  int          ev_idx   [6];
  logic [31:0] ev_data  [6];
  int          ev_n = 0;

  function automatic logic [31:0] model_div(input logic [31:0] v, input logic [RW-1:0] r);
    int e;
    int rr;
    e  = int'(v[30:23]);
    rr = int'(r);
    if (e == 255) return v;
    if (e == 0 || e <= rr) return {v[31], 31'h0};
    return {v[31], 8'(e - rr), v[22:0]};
  endfunction

  function automatic void push_expect(input int idx, input logic [31:0] e);
    sb.push_back(e);
`ifdef POTENTIAL_DECAY_TRACE_EN
    tr_q.push_back('{idx: IW'(idx), val: e});
`endif
    m_pot[idx] = e;
  endfunction

  function automatic void build_expect(input int coll_idx, input logic [31:0] coll_val);
    for (int i = 0; i < N; i++) begin
      if (i == coll_idx) push_expect(i, coll_val);
      else push_expect(i, model_div(m_pot[i], m_rate[i]));
    end
  endfunction

  task automatic set_neuron(input int idx, input logic [31:0] val, input bit do_cfg,
                            input logic [RW-1:0] rate);
    @(negedge clk);
    wr_en = 1'b1; wr_idx = IW'(idx); wr_potential = val;
    cfg_en = do_cfg; cfg_idx = IW'(idx); cfg_rate = rate;
    @(negedge clk);
    wr_en = 1'b0; cfg_en = 1'b0;
    m_pot[idx] = val;
    if (do_cfg) m_rate[idx] = rate;
  endtask

  task automatic apply_events(input int c);
    for (int k = 0; k < ev_n; k++) begin
      if (ev_cycle[k] == c) begin
        if (ev_kind[k] == 0) begin
          wr_en = 1'b1; wr_idx = IW'(ev_idx[k]); wr_potential = ev_data[k];
        end else begin
          cfg_en = 1'b1; cfg_idx = IW'(ev_idx[k]); cfg_rate = RW'(ev_data[k]);
        end
      end
    end
  endtask

  // Cycle c is the c-th cycle after the edge that accepts sweep_start (cycle 0 drives it).
  task automatic run_sweep(input int restart_at, output int done_cycle, output int done_cnt,
                           output bit busy_ok);
    bit     trace_bad;
    trace_t t;
    done_cycle = -1; done_cnt = 0; busy_ok = 1'b1; trace_bad = 1'b0;
    @(negedge clk);
    sweep_start = 1'b1;
    apply_events(0);
    @(negedge clk);
    for (int c = 1; c <= N + 8; c++) begin
      if (sweep_done === 1'b1) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (c <= N + 1 && busy !== 1'b1) busy_ok = 1'b0;
      if (c == N + 2 && busy !== 1'b0) busy_ok = 1'b0;
`ifdef POTENTIAL_DECAY_TRACE_EN
      if (trace_valid === 1'b1) begin
        checks++;
        if (tr_q.size() == 0) begin
          failures++;
          $display("FAIL trace_extra: got idx=%0d value=%h, required no trace", trace_idx,
                   trace_value);
        end else begin
          t = tr_q.pop_front();
          if (trace_idx !== t.idx || trace_value !== t.val) begin
            failures++;
            $display("FAIL trace_entry: got idx=%0d value=%h, required idx=%0d value=%h",
                     trace_idx, trace_value, t.idx, t.val);
          end
        end
      end
`else
      if (trace_valid !== 1'b0 || trace_idx !== '0 || trace_value !== '0) trace_bad = 1'b1;
`endif
      sweep_start = (c == restart_at);
      wr_en = 1'b0; cfg_en = 1'b0;
      apply_events(c);
      @(negedge clk);
    end
    sweep_start = 1'b0; wr_en = 1'b0; cfg_en = 1'b0;
    checks++;
`ifdef POTENTIAL_DECAY_TRACE_EN
    if (tr_q.size() != 0) begin
      failures++;
      $display("FAIL trace_missing: got %0d entries left over, required 0", tr_q.size());
      tr_q.delete();
    end
`else
    if (trace_bad) begin
      failures++;
      $display("FAIL trace_tied: got nonzero trace outputs, required all zero");
    end
`endif
  endtask

  task automatic check_contents(input string name);
    logic [31:0] e;
    for (int i = 0; i < N; i++) begin
      rd_idx = IW'(i);
      #1;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL %s idx %0d: got %h, required a queued value", name, i, rd_potential);
      end else begin
        e = sb.pop_front();
        if (rd_potential !== e) begin
          failures++;
          $display("FAIL %s idx %0d: got %h, required %h", name, i, rd_potential, e);
        end
      end
    end
  endtask

  task automatic check_timing(input string name, input int done_cycle, input int done_cnt,
                              input bit busy_ok);
    checks++;
    if (done_cnt !== 1 || done_cycle !== N + 1) begin
      failures++;
      $display("FAIL %s_done: got count=%0d cycle=%0d, required count=1 cycle=%0d", name,
               done_cnt, done_cycle, N + 1);
    end
    checks++;
    if (!busy_ok) begin
      failures++;
      $display("FAIL %s_busy: got busy profile wrong, required high cycles 1..%0d then low",
               name, N + 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_pot[i]  = 32'h0;
      m_rate[i] = RW'(1);
    end
    #1;
    checks++;
    if (busy !== 1'b0 || sweep_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got busy=%b done=%b, required 0 0", busy, sweep_done);
    end
    checks++;
    if (trace_valid !== 1'b0 || trace_idx !== '0 || trace_value !== '0) begin
      failures++;
      $display("FAIL reset_trace: got %b %0d %h, required 0 0 0", trace_valid, trace_idx,
               trace_value);
    end
    for (int i = 0; i < N; i++) sb.push_back(32'h0);
    check_contents("reset_pot");
  endtask

  task automatic test_decay_vectors();
    logic [31:0] vals [12] = '{32'h41200000, 32'h41200000, 32'hC1200000, 32'h00800000,
                               32'h80800000, 32'h7FC00000, 32'h3F800000, 32'h7F800000,
                               32'h00000001, 32'h01000000, 32'h01800000, 32'hFF800000};
    logic [31:0] exps [12] = '{32'h40A00000, 32'h3FA00000, 32'hC1200000, 32'h00000000,
                               32'h80000000, 32'h7FC00000, 32'h3F000000, 32'h7F800000,
                               32'h00000000, 32'h00000000, 32'h00800000, 32'hFF800000};
    logic [RW-1:0] rates [12] = '{3'd1, 3'd3, 3'd0, 3'd1, 3'd1, 3'd7, 3'd1, 3'd2,
                                  3'd0, 3'd2, 3'd2, 3'd5};
    logic [31:0] v;
    int dc, dn;
    bit bok;
    // idx 6 keeps the reset-default rate
    for (int i = 0; i < 12; i++) set_neuron(i, vals[i], (i != 6), rates[i]);
    for (int i = 12; i < N; i++) begin
      v = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      set_neuron(i, v, 1'b1, RW'($urandom));
    end
    for (int i = 0; i < N; i++) begin
      if (i < 12) push_expect(i, exps[i]);
      else push_expect(i, model_div(m_pot[i], m_rate[i]));
    end
    ev_n = 0;
    run_sweep(0, dc, dn, bok);
    check_timing("vectors", dc, dn, bok);
    check_contents("vectors");
  endtask

  task automatic test_interactions();
    int dc, dn;
    bit bok;
    set_neuron(7, 32'h44800000, 1'b0, '0);
    ev_n = 4;
    ev_cycle[0] = 0; ev_kind[0] = 0; ev_idx[0] = 0;  ev_data[0] = 32'h42000000;
    ev_cycle[1] = 3; ev_kind[1] = 0; ev_idx[1] = 12; ev_data[1] = 32'h40400000;
    ev_cycle[2] = 6; ev_kind[2] = 0; ev_idx[2] = 5;  ev_data[2] = 32'h3F800000;
    ev_cycle[3] = 8; ev_kind[3] = 1; ev_idx[3] = 7;  ev_data[3] = 32'd4;
    m_pot[0]  = 32'h42000000;
    m_pot[12] = 32'h40400000;
    build_expect(5, 32'h3F800000);
    run_sweep(0, dc, dn, bok);
    m_rate[7] = RW'(4);
    check_timing("interact", dc, dn, bok);
    check_contents("interact");
    ev_n = 0;
    build_expect(-1, '0);
    run_sweep(0, dc, dn, bok);
    check_timing("rate_next", dc, dn, bok);
    check_contents("rate_next");
  endtask

  task automatic test_back_to_back();
    int dc, dn;
    bit bok;
    ev_n = 0;
    build_expect(-1, '0);
    run_sweep(3, dc, dn, bok);
    check_timing("back_to_back", dc, dn, bok);
    check_contents("back_to_back");
  endtask

  task automatic test_reset_mid_sweep();
    int dc, dn;
    bit bok;
    int stray;
    set_neuron(9, 32'h41200000, 1'b0, '0);
    @(negedge clk);
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || sweep_done !== 1'b0) begin
      failures++;
      $display("FAIL midreset_ctrl: got busy=%b done=%b, required 0 0", busy, sweep_done);
    end
    sb.delete();
    tr_q.delete();
    for (int i = 0; i < N; i++) begin
      m_pot[i]  = 32'h0;
      m_rate[i] = RW'(1);
      sb.push_back(32'h0);
    end
    check_contents("midreset_pot");
    stray = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sweep_done !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL midreset_quiet: got %0d active cycles, required 0", stray);
    end
    set_neuron(3, 32'h41200000, 1'b0, '0);
    ev_n = 0;
    build_expect(-1, '0);
    run_sweep(0, dc, dn, bok);
    check_timing("after_reset", dc, dn, bok);
    checks++;
    if (m_pot[3] !== 32'h40A00000) begin
      failures++;
      $display("FAIL after_reset_model: got %h, required 40a00000", m_pot[3]);
    end
    check_contents("after_reset");
  endtask

  initial begin
    rst_n = 1'b0; sweep_start = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_potential = '0;
    cfg_en = 1'b0; cfg_idx = '0; cfg_rate = '0; rd_idx = '0;
    test_reset();
    test_decay_vectors();
    test_interactions();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/potential_decay_array.md
POTENTIAL_DECAY_ARRAY -- requirements
Module: potential_decay_array

Interface
REQ-001 Parameter NUM_NEURONS, default 16: number of neuron potentials held; must be ≥2 and a power of two.
REQ-002 Parameter RATE_W, default 3: width of each per-neuron decay-rate field.
REQ-003 Parameter DEFAULT_RATE, default 1: decay rate loaded into every neuron at reset.
REQ-004 Derived constant IDX_W = clog2(NUM_NEURONS).
REQ-005 CLK  input  1  single clock; all state updates on the rising edge.
REQ-006 RESET_N  input  1  asynchronous, active-low reset.
REQ-007 sweep_start  input  1  request one decay sweep over all neurons.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 sweep_done  output  1  one-cycle pulse when a sweep completes.
REQ-010 wr_en / wr_idx / wr_potential  input  1 / IDX_W / 32  host write of one IEEE-754 single-precision potential.
REQ-011 cfg_en / cfg_idx / cfg_rate  input  1 / IDX_W / RATE_W  host write of one neuron's decay rate.
REQ-012 rd_idx / rd_potential  input IDX_W / output 32  combinational read of the stored potential.
REQ-013 trace_valid / trace_idx / trace_value  output  1 / IDX_W / 32  per-neuron decay result stream.

Function
REQ-014 Decay divides the stored float32 by 2^rate using exponent subtraction only; the sign and mantissa are preserved.
REQ-015 With rate = 0, the value is unchanged.
REQ-016 Exponent 0xFF (Inf/NaN) passes unchanged.
REQ-017 Exponent 0 (zero/denormal) flushes to signed zero.
REQ-018 If exponent ≤ rate, the result is signed zero (sign kept, all other bits 0); no denormals are produced.
REQ-019 The FSM has three states: IDLE, SWEEP, DONE.
REQ-020 IDLE→SWEEP on sweep_start; the index counter is set to 0.
REQ-021 SWEEP: one neuron per cycle, in the order idx 0..NUM_NEURONS-1; after the last index → DONE.
REQ-022 DONE: sweep_done=1 for exactly one cycle, then → IDLE.
REQ-023 busy=1 in SWEEP and DONE.
REQ-024 sweep_start while busy is ignored; there is no queuing.
REQ-025 Latency: sweep_done is high in cycle NUM_NEURONS+1 after the edge that accepted sweep_start.
REQ-026 Collision: a host write to the index being decayed in the same cycle wins, and the decay result for that index is discarded.
REQ-027 Host writes to other indices during a sweep take effect normally.
REQ-028 A cfg_en write to the currently swept index takes effect from the next sweep; the rate used in the current cycle is the pre-write value.
REQ-029 A simultaneous wr_en and sweep_start in IDLE: the write lands first, and the sweep sees the written value.
REQ-030 rd_potential reflects the register contents; it is not bypassed from same-cycle writes.

Reset
REQ-031 On RESET_N=0: all potentials 0x00000000; all rates DEFAULT_RATE; state IDLE; index 0; busy=0; sweep_done=0; trace_valid=0; trace_idx=0; trace_value=0.
REQ-032 Reset asserted mid-sweep aborts the sweep immediately, and no sweep_done pulse is issued.

Configuration
REQ-033 Macro POTENTIAL_DECAY_TRACE_EN, when defined: each SWEEP cycle registers trace_valid=1, trace_idx=swept index, and trace_value=the value written, or the host value on collision. These appear one cycle after the decay edge.
REQ-034 When POTENTIAL_DECAY_TRACE_EN is undefined, the trace outputs are tied to 0 and no trace registers are synthesised.

Structure
REQ-035 Shared package potential_decay_pkg holds the following:
- float32 field constants (SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_W=23, EXP_MAX=8'hFF);
- typedef float32_t;
- FSM state enum.
REQ-036 The combinational sub-module fp_pow2_div (inputs: value, rate; output: result) implements REQ-014..REQ-018 and is instantiated once.

Verification
REQ-037 Store 0x41200000 (10.0) at idx 0 with rate 1, then pulse sweep_start → idx 0 reads 0x40A00000 (5.0) after sweep_done.
REQ-038 Store 0x41200000 with rate 3 → 0x3FA00000 (1.25); store 0xC1200000 with rate 0 → unchanged.
REQ-039 Store 0x00800000 with rate 1 → 0x00000000; store 0x80800000 with rate 1 → 0x80000000; store 0x7FC00000 with rate 7 → 0x7FC00000.
REQ-040 With NUM_NEURONS=16, pulse sweep_start, then pulse it again 3 cycles later → exactly one sweep_done, 17 cycles after the first start; busy is high throughout.
REQ-041 Write 0x3F800000 to idx 5 in the cycle idx 5 is swept → idx 5 reads 0x3F800000; if the trace is enabled, trace_idx=5 and trace_value=0x3F800000.
REQ-042 Assert RESET_N low at sweep index 8 → all potentials read 0, busy=0, and no sweep_done; a following sweep completes normally.
